// File: rtl/demux_stream_1ton.sv
// Registered 1:N stream demultiplexer: one input beat is routed to one of N
// one-deep output registers. Optional per-channel handshake counters: DEMUX_STATS_EN.
module demux_stream_1ton #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int CW = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SW-1:0]   in_sel,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            drop,
  input  logic            cnt_clr,
  output logic [N*CW-1:0] cnt
);

  // Handshake: a beat moves on any edge where valid & ready are both high.
  // in_ready is a function of in_sel and the target channel only (never of
  // in_valid), and an out-of-range select is always ready so it gets dropped.
  logic [N-1:0]         valid_q;
  logic [N-1:0][DW-1:0] data_q;
  logic [N-1:0]         free;
  logic [N-1:0]         load;
  logic                 sel_in_range;
  logic                 drop_q;

  assign free         = ~valid_q | out_ready;
  assign sel_in_range = (32'(in_sel) < 32'(N));

  always_comb begin
    in_ready = 1'b1;
    load     = '0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SW'(k)) begin
        in_ready = free[k];
        load[k]  = in_valid & free[k];
      end
    end
  end

  // A reload wins over a drain, so a simultaneous handshake keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= in_valid & ~sel_in_range;
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= in_data;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop      = drop_q;

`ifdef DEMUX_STATS_EN
  logic [N-1:0][CW-1:0] cnt_q;

  // Saturating counters; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (valid_q[k] && out_ready[k] && (cnt_q[k] != {CW{1'b1}})) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign cnt            = '0;
`endif

endmodule
